adc_parallel_sequencer: RTL and testbench
=========================================

// Module: adc_parallel_sequencer
// PURPOSE
//  Multi-channel sequencer for the parallel-output ADC on the FMC header. Drives CONVST/RD/PD,
//  steps an external analog mux over NUM_CH channels, captures ADC_D on each end-of-conversion
//  and delivers {channel, sample} on a valid/ready stream to the downstream capture logic.
//  Supports single-scan and continuous modes, power-down with wake-up delay, and EOC timeout.
// PARAMETERS
//  DATA_W      12   ADC data bus width
//  NUM_CH      4    channels per scan (1..16); CH_W = max(1, clog2(NUM_CH))
//  CONV_LOW    4    CONVST low pulse width, clk cycles (>=1)
//  RD_LOW      7    RD low width before capture, clk cycles (>=1; 7 = 70 ns)
//  PWRUP_CYC   100  wait after PD release before first conversion, cycles
//  EOC_TMO     2000 max cycles in WAIT_EOC before timeout
// PORTS
//  clk_100M     in   1       100 MHz system clock
//  Reset        in   1       async active-low reset
//  start        in   1       1-cycle pulse: begin a scan (ignored unless IDLE)
//  continuous   in   1       1: rescan from ch 0 after last channel until cleared
//  pd_req       in   1       1: enter power-down at next scan boundary
//  EOC_18       in   1       ADC end-of-conversion, active low, async (2-FF synchronised)
//  ADC_D        in   DATA_W  ADC parallel data, valid while RD_18 low
//  CONVST_18    out  1       convert start, active low
//  RD_18        out  1       read strobe, active low
//  PD_18        out  1       ADC power-down, active high
//  ch_sel       out  CH_W    analog mux address
//  m_valid      out  1       sample available
//  m_ready      in   1       downstream accepts when m_valid&m_ready
//  m_data       out  DATA_W  captured sample
//  m_ch         out  CH_W    channel of m_data
//  busy         out  1       1 in any state except IDLE/PDOWN
//  tmo_err      out  1       sticky; set on EOC timeout, cleared by start
// BEHAVIOUR
//  Reset (async): state=PDOWN, PD_18=1, CONVST_18=1, RD_18=1, ch_sel=0, m_valid=0,
//   m_data=0, m_ch=0, busy=0, tmo_err=0. All outputs registered.
//  States: PDOWN, WAKE, IDLE, CONV, WAIT_EOC, READ, HOLD.
//  PDOWN: PD_18=1. pd_req=0 -> WAKE (PD_18=0, counter PWRUP_CYC) -> IDLE.
//  IDLE: pd_req=1 -> PDOWN. start -> ch_sel=0, tmo_err=0, CONV.
//  CONV: CONVST_18=0 exactly CONV_LOW cycles, then 1 -> WAIT_EOC.
//  WAIT_EOC: synchronised EOC low -> READ. EOC_TMO cycles elapsed -> tmo_err=1,
//   drop channel, go to IDLE (scan aborted, continuous ignored until next start).
//  READ: RD_18=0 for RD_LOW cycles; ADC_D sampled on last low cycle into m_data,
//   m_ch=ch_sel; RD_18=1 next cycle; -> HOLD with m_valid=1.
//  HOLD: wait m_valid&m_ready (m_data/m_ch stable while m_valid). On accept m_valid=0 and:
//   ch_sel<NUM_CH-1 -> ch_sel+1, CONV; else ch_sel wraps to 0 and
//   pd_req=1 -> PDOWN; continuous=1 -> CONV; else IDLE.
//  Latency: CONVST falling to m_valid = CONV_LOW + EOC delay + 2 sync + RD_LOW + 1 cycles.
//  pd_req/continuous changes mid-scan take effect only at scan boundary.
//  start while busy: ignored. NUM_CH=1: ch_sel stays 0.
//  Reset mid-operation: immediate return to reset values; pending sample discarded.
// TESTING
//  1 Reset, pd_req=0, NUM_CH=4, start, EOC 300 ns after CONVST, ADC_D=ch*0x111, m_ready=1 ->
//    4 beats m_ch 0..3, m_data 0x000,0x111,0x222,0x333; CONVST low 4 cyc, RD low 7 cyc; IDLE.
//  2 continuous=1, m_ready=1 -> ch 0,1,2,3,0,1..; clear continuous mid-scan -> ends after ch 3.
//  3 m_ready=0 for 50 cycles at ch 1 -> m_valid held, m_data stable, no CONVST for ch 2 until accept.
//  4 EOC held high -> tmo_err=1 after EOC_TMO cycles, state IDLE, busy=0; next start clears tmo_err.
//  5 pd_req=1 at ch 2 -> scan completes ch 3 then PD_18=1; release -> PD_18=0, start honoured only
//    after PWRUP_CYC cycles.
//  6 Reset low during READ -> RD_18=1, m_valid=0, PD_18=1 same cycle; start during busy ignored.

Source files
------------

// File: rtl/adc_parallel_sequencer.sv
// Multi-channel sequencer for the FMC parallel ADC: drives CONVST/RD/PD, steps the analog mux
// and streams {channel, sample} on a valid/ready interface.
module adc_parallel_sequencer #(
    parameter int DATA_W    = 12,
    parameter int NUM_CH    = 4,
    parameter int CONV_LOW  = 4,
    parameter int RD_LOW    = 7,
    parameter int PWRUP_CYC = 100,
    parameter int EOC_TMO   = 2000,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_100M,
    input  logic              Reset,
    input  logic              start,
    input  logic              continuous,
    input  logic              pd_req,
    input  logic              EOC_18,
    input  logic [DATA_W-1:0] ADC_D,
    output logic              CONVST_18,
    output logic              RD_18,
    output logic              PD_18,
    output logic [CH_W-1:0]   ch_sel,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic [CH_W-1:0]   m_ch,
    output logic              busy,
    output logic              tmo_err
);

    localparam int M1      = (PWRUP_CYC > EOC_TMO) ? PWRUP_CYC : EOC_TMO;
    localparam int M2      = (CONV_LOW > RD_LOW) ? CONV_LOW : RD_LOW;
    localparam int CNT_MAX = (M1 > M2) ? M1 : M2;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        PDOWN, WAKE, IDLE, CONV, WAIT_EOC, READ, HOLD
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                convst_d, rd_d, pd_d, valid_d, busy_d, tmo_d;
    logic [CH_W-1:0]     ch_d, mch_d;
    logic [DATA_W-1:0]   data_d;
    logic                eoc_p0, eoc_p1;

    // EOC is asynchronous to clk_100M: two-flop synchroniser, idles high
    always_ff @(posedge clk_100M or negedge Reset) begin
        if (!Reset) begin
            eoc_p0 <= 1'b1;
            eoc_p1 <= 1'b1;
        end else begin
            eoc_p0 <= EOC_18;
            eoc_p1 <= eoc_p0;
        end
    end

    always_ff @(posedge clk_100M or negedge Reset) begin
        if (!Reset) begin
            state_q   <= PDOWN;
            cnt_q     <= '0;
            CONVST_18 <= 1'b1;
            RD_18     <= 1'b1;
            PD_18     <= 1'b1;
            ch_sel    <= '0;
            m_valid   <= 1'b0;
            m_data    <= '0;
            m_ch      <= '0;
            busy      <= 1'b0;
            tmo_err   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            CONVST_18 <= convst_d;
            RD_18     <= rd_d;
            PD_18     <= pd_d;
            ch_sel    <= ch_d;
            m_valid   <= valid_d;
            m_data    <= data_d;
            m_ch      <= mch_d;
            busy      <= busy_d;
            tmo_err   <= tmo_d;
        end
    end

    // Next-state logic computes the value every output takes after the coming edge
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        convst_d = 1'b1;
        rd_d     = 1'b1;
        pd_d     = 1'b0;
        ch_d     = ch_sel;
        valid_d  = m_valid;
        data_d   = m_data;
        mch_d    = m_ch;
        tmo_d    = tmo_err;
        case (state_q)
            PDOWN: begin
                if (!pd_req) begin
                    state_d = WAKE;
                    cnt_d   = CNT_W'(PWRUP_CYC - 1);
                end else begin
                    pd_d = 1'b1;
                end
            end
            WAKE: begin
                if (cnt_q == '0) state_d = IDLE;
                else             cnt_d   = cnt_q - CNT_W'(1);
            end
            IDLE: begin
                if (pd_req) begin
                    state_d = PDOWN;
                    pd_d    = 1'b1;
                end else if (start) begin
                    state_d  = CONV;
                    ch_d     = '0;
                    tmo_d    = 1'b0;
                    convst_d = 1'b0;
                    cnt_d    = CNT_W'(CONV_LOW - 1);
                end
            end
            CONV: begin
                if (cnt_q == '0) begin
                    state_d = WAIT_EOC;
                    cnt_d   = CNT_W'(EOC_TMO - 1);
                end else begin
                    convst_d = 1'b0;
                    cnt_d    = cnt_q - CNT_W'(1);
                end
            end
            WAIT_EOC: begin
                if (!eoc_p1) begin
                    state_d = READ;
                    rd_d    = 1'b0;
                    cnt_d   = CNT_W'(RD_LOW - 1);
                end else if (cnt_q == '0) begin
                    // Abandon the whole scan; continuous mode needs a fresh start
                    state_d = IDLE;
                    tmo_d   = 1'b1;
                    ch_d    = '0;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            READ: begin
                if (cnt_q == '0) begin
                    state_d = HOLD;
                    data_d  = ADC_D;
                    mch_d   = ch_sel;
                    valid_d = 1'b1;
                end else begin
                    rd_d  = 1'b0;
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            HOLD: begin
                if (m_ready) begin
                    valid_d = 1'b0;
                    if (ch_sel < CH_W'(NUM_CH - 1)) begin
                        ch_d     = ch_sel + CH_W'(1);
                        state_d  = CONV;
                        convst_d = 1'b0;
                        cnt_d    = CNT_W'(CONV_LOW - 1);
                    end else begin
                        ch_d = '0;
                        if (pd_req) begin
                            state_d = PDOWN;
                            pd_d    = 1'b1;
                        end else if (continuous) begin
                            state_d  = CONV;
                            convst_d = 1'b0;
                            cnt_d    = CNT_W'(CONV_LOW - 1);
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: begin
                state_d = PDOWN;
                pd_d    = 1'b1;
            end
        endcase
        busy_d = (state_d != IDLE) && (state_d != PDOWN);
    end

endmodule

// File: tb/tb_adc_parallel_sequencer.sv
// Directed bench for adc_parallel_sequencer with a behavioural ADC: EOC falls 305 ns after
// CONVST falls and rises again on RD falling; ADC_D = ch_sel * 0x111 (optionally inverted).
`timescale 1ns/1ps
module tb_adc_parallel_sequencer;

    localparam int DATA_W    = 12;
    localparam int NUM_CH    = 4;
    localparam int CONV_LOW  = 4;
    localparam int RD_LOW    = 7;
    localparam int PWRUP_CYC = 100;
    localparam int EOC_TMO   = 2000;

    logic        clk_100M = 1'b0;
    logic        Reset, start, continuous, pd_req, m_ready;
    logic        EOC_18;
    logic [11:0] ADC_D;
    logic        CONVST_18, RD_18, PD_18, m_valid, busy, tmo_err;
    logic [1:0]  ch_sel, m_ch;
    logic [11:0] m_data;
    logic [11:0] adc_xor;
    logic        eoc_en;

    int total = 0;
    int bad   = 0;
    int eoc_fall = 0;
    int eoc_rise = 0;
    int conv_run = 0, conv_w = 0, rd_run = 0, rd_w = 0, conv_falls = 0;
    logic [1:0]  beat_ch[$];
    logic [11:0] beat_data[$];

    adc_parallel_sequencer #(
        .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CONV_LOW(CONV_LOW), .RD_LOW(RD_LOW),
        .PWRUP_CYC(PWRUP_CYC), .EOC_TMO(EOC_TMO)
    ) dut (
        .clk_100M(clk_100M), .Reset(Reset), .start(start), .continuous(continuous),
        .pd_req(pd_req), .EOC_18(EOC_18), .ADC_D(ADC_D), .CONVST_18(CONVST_18),
        .RD_18(RD_18), .PD_18(PD_18), .ch_sel(ch_sel), .m_valid(m_valid),
        .m_ready(m_ready), .m_data(m_data), .m_ch(m_ch), .busy(busy), .tmo_err(tmo_err)
    );

    always #5 clk_100M = ~clk_100M;

    assign ADC_D  = (12'h111 * {10'd0, ch_sel}) ^ adc_xor;
    assign EOC_18 = (eoc_fall == eoc_rise);

    always @(negedge CONVST_18) begin
        conv_falls++;
        if (eoc_en) begin
            #305;
            eoc_fall = eoc_rise + 1;
        end
    end

    always @(negedge RD_18 or negedge Reset) eoc_rise = eoc_fall;

    always @(negedge clk_100M) begin
        if (!CONVST_18) conv_run++;
        else if (conv_run != 0) begin conv_w = conv_run; conv_run = 0; end
        if (!RD_18) rd_run++;
        else if (rd_run != 0) begin rd_w = rd_run; rd_run = 0; end
        if (m_valid && m_ready) begin
            beat_ch.push_back(m_ch);
            beat_data.push_back(m_data);
        end
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation exceeded 1 ms");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_100M);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int max, input string name);
        int n = 0;
        while (busy && n < max) begin tick(1); n++; end
        total++;
        if (busy !== 1'b0) begin bad++; $display("FAIL %s idle timeout busy=%b want 0", name, busy); end
    endtask

    task automatic wait_beats(input int base, input int cnt, input string name);
        int n = 0;
        while ((beat_ch.size() - base) < cnt && n < 1000) begin tick(1); n++; end
        total++;
        if ((beat_ch.size() - base) < cnt) begin
            bad++; $display("FAIL %s beat timeout got=%0d want>=%0d", name, beat_ch.size() - base, cnt);
        end
    endtask

    task automatic test_reset();
        tick(3);
        total++; if (PD_18 !== 1'b1)     begin bad++; $display("FAIL rst_pd got=%b want=1", PD_18); end
        total++; if (CONVST_18 !== 1'b1) begin bad++; $display("FAIL rst_convst got=%b want=1", CONVST_18); end
        total++; if (RD_18 !== 1'b1)     begin bad++; $display("FAIL rst_rd got=%b want=1", RD_18); end
        total++; if (ch_sel !== 2'd0)    begin bad++; $display("FAIL rst_ch got=%0d want=0", ch_sel); end
        total++; if (m_valid !== 1'b0)   begin bad++; $display("FAIL rst_valid got=%b want=0", m_valid); end
        total++; if (m_data !== 12'h000) begin bad++; $display("FAIL rst_data got=%h want=000", m_data); end
        total++; if (m_ch !== 2'd0)      begin bad++; $display("FAIL rst_mch got=%0d want=0", m_ch); end
        total++; if (busy !== 1'b0)      begin bad++; $display("FAIL rst_busy got=%b want=0", busy); end
        total++; if (tmo_err !== 1'b0)   begin bad++; $display("FAIL rst_tmo got=%b want=0", tmo_err); end
        Reset = 1'b1;
        tick(1);
        total++; if (PD_18 !== 1'b0) begin bad++; $display("FAIL wake_pd got=%b want=0", PD_18); end
        total++; if (busy !== 1'b1)  begin bad++; $display("FAIL wake_busy got=%b want=1", busy); end
        wait_idle(PWRUP_CYC + 10, "wake");
    endtask

    task automatic test_single_scan();
        int base = beat_ch.size();
        int cf   = conv_falls;
        pulse_start();
        total++; if (busy !== 1'b1) begin bad++; $display("FAIL scan_busy got=%b want=1", busy); end
        wait_idle(400, "scan");
        total++; if (beat_ch.size() - base != 4) begin bad++; $display("FAIL scan_beats got=%0d want=4", beat_ch.size() - base); end
        for (int i = 0; i < 4 && base + i < beat_ch.size(); i++) begin
            total++; if (beat_ch[base+i] !== 2'(i)) begin bad++; $display("FAIL scan_ch%0d got=%0d want=%0d", i, beat_ch[base+i], i); end
            total++; if (beat_data[base+i] !== 12'(12'h111 * i)) begin bad++; $display("FAIL scan_data%0d got=%h want=%h", i, beat_data[base+i], 12'(12'h111 * i)); end
        end
        total++; if (conv_w != CONV_LOW)     begin bad++; $display("FAIL convst_width got=%0d want=%0d", conv_w, CONV_LOW); end
        total++; if (rd_w != RD_LOW)         begin bad++; $display("FAIL rd_width got=%0d want=%0d", rd_w, RD_LOW); end
        total++; if (conv_falls - cf != 4)   begin bad++; $display("FAIL scan_convs got=%0d want=4", conv_falls - cf); end
        total++; if (ch_sel !== 2'd0)        begin bad++; $display("FAIL scan_ch_wrap got=%0d want=0", ch_sel); end
        total++; if (m_valid !== 1'b0)       begin bad++; $display("FAIL scan_valid_end got=%b want=0", m_valid); end
    endtask

    task automatic test_continuous();
        int base = beat_ch.size();
        continuous = 1'b1;
        pulse_start();
        wait_beats(base, 6, "cont");
        continuous = 1'b0;
        wait_idle(400, "cont");
        total++; if (beat_ch.size() - base != 8) begin bad++; $display("FAIL cont_beats got=%0d want=8", beat_ch.size() - base); end
        for (int i = 0; i < 8 && base + i < beat_ch.size(); i++) begin
            total++; if (beat_ch[base+i] !== 2'(i % 4)) begin bad++; $display("FAIL cont_ch%0d got=%0d want=%0d", i, beat_ch[base+i], i % 4); end
        end
        total++; if (beat_data[base+4] !== 12'h000) begin bad++; $display("FAIL cont_data4 got=%h want=000", beat_data[base+4]); end
    endtask

    task automatic test_backpressure();
        int base = beat_ch.size();
        int n = 0;
        int errs = 0;
        int cf;
        pulse_start();
        wait_beats(base, 1, "bp_ch0");
        m_ready = 1'b0;
        while (!m_valid && n < 200) begin tick(1); n++; end
        total++; if (m_valid !== 1'b1 || m_ch !== 2'd1) begin bad++; $display("FAIL bp_hold valid=%b ch=%0d want 1/1", m_valid, m_ch); end
        cf = conv_falls;
        adc_xor = 12'hFFF;
        for (int i = 0; i < 50; i++) begin
            tick(1);
            if (m_valid !== 1'b1 || m_data !== 12'h111 || m_ch !== 2'd1) errs++;
        end
        total++; if (errs != 0) begin bad++; $display("FAIL bp_stable got=%0d bad cycles want=0", errs); end
        total++; if (conv_falls != cf) begin bad++; $display("FAIL bp_no_conv got=%0d want=%0d", conv_falls, cf); end
        adc_xor = 12'h000;
        m_ready = 1'b1;
        wait_idle(400, "bp");
        total++; if (beat_ch.size() - base != 4) begin bad++; $display("FAIL bp_beats got=%0d want=4", beat_ch.size() - base); end
        if (beat_ch.size() - base >= 3) begin
            total++; if (beat_data[base+1] !== 12'h111) begin bad++; $display("FAIL bp_data1 got=%h want=111", beat_data[base+1]); end
            total++; if (beat_data[base+2] !== 12'h222) begin bad++; $display("FAIL bp_data2 got=%h want=222", beat_data[base+2]); end
        end
    endtask

    task automatic test_timeout();
        int base = beat_ch.size();
        int n = 0;
        eoc_en = 1'b0;
        continuous = 1'b1;
        pulse_start();
        while (!tmo_err && n < 3000) begin tick(1); n++; end
        total++; if (tmo_err !== 1'b1) begin bad++; $display("FAIL tmo_set got=%b want=1", tmo_err); end
        total++; if (n != CONV_LOW + EOC_TMO) begin bad++; $display("FAIL tmo_cycles got=%0d want=%0d", n, CONV_LOW + EOC_TMO); end
        total++; if (busy !== 1'b0 || ch_sel !== 2'd0) begin bad++; $display("FAIL tmo_idle busy=%b ch=%0d want 0/0", busy, ch_sel); end
        tick(10);
        total++; if (busy !== 1'b0 || tmo_err !== 1'b1) begin bad++; $display("FAIL tmo_sticky busy=%b tmo=%b want 0/1", busy, tmo_err); end
        total++; if (beat_ch.size() != base) begin bad++; $display("FAIL tmo_nobeat got=%0d want=0", beat_ch.size() - base); end
        continuous = 1'b0;
        eoc_en = 1'b1;
        pulse_start();
        total++; if (tmo_err !== 1'b0) begin bad++; $display("FAIL tmo_clear got=%b want=0", tmo_err); end
        wait_idle(400, "tmo_rescan");
        total++; if (beat_ch.size() - base != 4) begin bad++; $display("FAIL tmo_rescan got=%0d want=4", beat_ch.size() - base); end
    endtask

    task automatic test_powerdown();
        int base = beat_ch.size();
        int n = 0;
        int cf;
        pulse_start();
        wait_beats(base, 2, "pd");
        pd_req = 1'b1;
        wait_idle(400, "pd");
        total++; if (beat_ch.size() - base != 4) begin bad++; $display("FAIL pd_beats got=%0d want=4", beat_ch.size() - base); end
        total++; if (PD_18 !== 1'b1) begin bad++; $display("FAIL pd_enter got=%b want=1", PD_18); end
        cf = conv_falls;
        pulse_start();
        tick(2);
        total++; if (busy !== 1'b0 || conv_falls != cf) begin bad++; $display("FAIL pd_start_ign busy=%b convs=%0d want 0/%0d", busy, conv_falls, cf); end
        pd_req = 1'b0;
        tick(1);
        total++; if (PD_18 !== 1'b0) begin bad++; $display("FAIL pd_release got=%b want=0", PD_18); end
        while (busy && n < 300) begin start = (n == 50); tick(1); n++; end
        start = 1'b0;
        total++; if (n != PWRUP_CYC) begin bad++; $display("FAIL pd_wake_cycles got=%0d want=%0d", n, PWRUP_CYC); end
        total++; if (conv_falls != cf) begin bad++; $display("FAIL pd_wake_start got=%0d want=%0d", conv_falls, cf); end
        pulse_start();
        total++; if (CONVST_18 !== 1'b0) begin bad++; $display("FAIL pd_start_ok got=%b want=0", CONVST_18); end
        wait_idle(400, "pd_rescan");
    endtask

    task automatic test_reset_mid();
        int base = beat_ch.size();
        int cf = conv_falls;
        int n = 0;
        pulse_start();
        tick(10);
        pulse_start();
        wait_idle(400, "busy_start");
        total++; if (beat_ch.size() - base != 4 || conv_falls - cf != 4) begin
            bad++; $display("FAIL busy_start_ign beats=%0d convs=%0d want 4/4", beat_ch.size() - base, conv_falls - cf); end
        pulse_start();
        while (RD_18 && n < 200) begin tick(1); n++; end
        tick(2);
        base = beat_ch.size();
        Reset = 1'b0;
        #1;
        total++; if (RD_18 !== 1'b1)   begin bad++; $display("FAIL mid_rd got=%b want=1", RD_18); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", m_valid); end
        total++; if (PD_18 !== 1'b1)   begin bad++; $display("FAIL mid_pd got=%b want=1", PD_18); end
        total++; if (busy !== 1'b0)    begin bad++; $display("FAIL mid_busy got=%b want=0", busy); end
        tick(3);
        Reset = 1'b1;
        tick(1);
        wait_idle(PWRUP_CYC + 10, "mid_wake");
        total++; if (beat_ch.size() != base) begin bad++; $display("FAIL mid_discard got=%0d want=0", beat_ch.size() - base); end
        pulse_start();
        wait_idle(400, "mid_rescan");
        total++; if (beat_ch.size() - base != 4) begin bad++; $display("FAIL mid_rescan got=%0d want=4", beat_ch.size() - base); end
    endtask

    initial begin
        Reset = 1'b0; start = 1'b0; continuous = 1'b0; pd_req = 1'b0;
        m_ready = 1'b1; adc_xor = 12'h000; eoc_en = 1'b1;
        test_reset();
        test_single_scan();
        test_continuous();
        test_backpressure();
        test_timeout();
        test_powerdown();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
